// File: rtl/hex_sb_ctrl_mp.sv
// System-bus slave for a multiplexed N-digit 7-segment display.
// Holds digit/enable/blink/dp/period registers, scans the digits and drives registered outputs.
module hex_sb_ctrl_mp #(
   parameter int unsigned N_DIGITS  = 8,
   parameter int unsigned SCAN_DIV  = 1024,
   parameter int unsigned BLINK_W   = 24,
   parameter int unsigned BLINK_DEF = 2**23
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [31:0]         addr_i,
   input  logic                req_i,
   input  logic [31:0]         write_data_i,
   input  logic                write_enable_i,
   output logic [31:0]         read_data_o,
   output logic [6:0]          hex_led_o,
   output logic                hex_dp_o,
   output logic [N_DIGITS-1:0] hex_sel_o
);

   localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned N_PACK = (N_DIGITS < 8) ? N_DIGITS : 8;

   localparam logic [31:0] ADDR_ENABLE  = 32'h40;
   localparam logic [31:0] ADDR_BLINK   = 32'h44;
   localparam logic [31:0] ADDR_DP      = 32'h48;
   localparam logic [31:0] ADDR_PACKED  = 32'h4C;
   localparam logic [31:0] ADDR_PERIOD  = 32'h50;
   localparam logic [31:0] ADDR_SOFTRST = 32'h54;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'h0: seg_decode = 7'h40;
         4'h1: seg_decode = 7'h79;
         4'h2: seg_decode = 7'h24;
         4'h3: seg_decode = 7'h30;
         4'h4: seg_decode = 7'h19;
         4'h5: seg_decode = 7'h12;
         4'h6: seg_decode = 7'h02;
         4'h7: seg_decode = 7'h78;
         4'h8: seg_decode = 7'h00;
         4'h9: seg_decode = 7'h10;
         4'hA: seg_decode = 7'h08;
         4'hB: seg_decode = 7'h03;
         4'hC: seg_decode = 7'h46;
         4'hD: seg_decode = 7'h21;
         4'hE: seg_decode = 7'h06;
         default: seg_decode = 7'h0E;
      endcase
   endfunction

   logic [3:0]          digit_q [N_DIGITS];
   logic [N_DIGITS-1:0] en_q;
   logic [N_DIGITS-1:0] blink_q;
   logic [N_DIGITS-1:0] dp_q;
   logic [BLINK_W-1:0]  period_q;
   logic [SCAN_W-1:0]   scan_cnt_q;
   logic [IDX_W-1:0]    idx_q;
   logic [BLINK_W-1:0]  blink_cnt_q;
   logic                phase_q;

   logic                wr_c;
   logic                rd_c;
   logic                is_digit_c;
   logic                nib_ok_c;
   logic                mask_ok_c;
   logic                per_wr_c;
   logic                soft_c;
   logic [31:0]         rdata_c;
   logic [N_DIGITS-1:0] sel_c;
   logic [6:0]          seg_c;

   // Bus request decode and write-acceptance qualifiers
   assign wr_c       = req_i & write_enable_i;
   assign rd_c       = req_i & ~write_enable_i;
   assign is_digit_c = (addr_i[31:6] == 26'd0) && (addr_i[1:0] == 2'd0)
                       && (32'(addr_i[5:2]) < N_DIGITS);
   assign nib_ok_c   = (write_data_i[31:4] == 28'd0);
   assign mask_ok_c  = ((64'(write_data_i) >> N_DIGITS) == 64'd0);
   assign per_wr_c   = wr_c && (addr_i == ADDR_PERIOD) && (write_data_i != 32'd0)
                       && ((64'(write_data_i) >> BLINK_W) == 64'd0);
   assign soft_c     = wr_c && (addr_i == ADDR_SOFTRST) && (write_data_i == 32'd1);

   // Configuration registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned k = 0; k < N_DIGITS; k++) digit_q[k] <= 4'd0;
         en_q     <= '1;
         blink_q  <= '0;
         dp_q     <= '0;
         period_q <= BLINK_W'(BLINK_DEF);
      end else if (soft_c) begin
         for (int unsigned k = 0; k < N_DIGITS; k++) digit_q[k] <= 4'd0;
         en_q     <= '1;
         blink_q  <= '0;
         dp_q     <= '0;
         period_q <= BLINK_W'(BLINK_DEF);
      end else if (wr_c) begin
         for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (is_digit_c && nib_ok_c && (addr_i[5:2] == 4'(k)))
               digit_q[k] <= write_data_i[3:0];
         end
         if (addr_i == ADDR_PACKED) begin
            for (int unsigned k = 0; k < N_PACK; k++) digit_q[k] <= write_data_i[4*k +: 4];
         end
         if ((addr_i == ADDR_ENABLE) && mask_ok_c) en_q    <= write_data_i[N_DIGITS-1:0];
         if ((addr_i == ADDR_BLINK)  && mask_ok_c) blink_q <= write_data_i[N_DIGITS-1:0];
         if ((addr_i == ADDR_DP)     && mask_ok_c) dp_q    <= write_data_i[N_DIGITS-1:0];
         if (per_wr_c) period_q <= write_data_i[BLINK_W-1:0];
      end
   end

   // Read mux; anything not mapped returns a marker pattern
   always_comb begin
      rdata_c = 32'hDEAD_BEEF;
      case (addr_i)
         ADDR_ENABLE: rdata_c = 32'(en_q);
         ADDR_BLINK:  rdata_c = 32'(blink_q);
         ADDR_DP:     rdata_c = 32'(dp_q);
         ADDR_PERIOD: rdata_c = 32'(period_q);
         ADDR_PACKED: begin
            rdata_c = 32'd0;
            for (int unsigned k = 0; k < N_PACK; k++) rdata_c[4*k +: 4] = digit_q[k];
         end
         default: ;
      endcase
      for (int unsigned k = 0; k < N_DIGITS; k++) begin
         if (is_digit_c && (addr_i[5:2] == 4'(k))) rdata_c = 32'(digit_q[k]);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   read_data_o <= 32'd0;
      else if (rd_c) read_data_o <= rdata_c;
   end

   always_comb begin
      sel_c        = '1;
      sel_c[idx_q] = ~(en_q[idx_q] & ~(blink_q[idx_q] & phase_q));
      seg_c        = seg_decode(digit_q[idx_q]);
   end

   // Scan divider, blink timer and registered display outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scan_cnt_q  <= '0;
         idx_q       <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         hex_sel_o   <= '1;
         hex_led_o   <= 7'h7F;
         hex_dp_o    <= 1'b1;
      end else if (soft_c) begin
         scan_cnt_q  <= '0;
         idx_q       <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         hex_sel_o   <= '1;
         hex_led_o   <= 7'h7F;
         hex_dp_o    <= 1'b1;
      end else begin
         if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_q <= '0;
            idx_q      <= (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
         end else begin
            scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
         end
         if (per_wr_c) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
         end else if (blink_cnt_q >= period_q - BLINK_W'(1)) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
         end
         hex_sel_o <= sel_c;
         hex_led_o <= seg_c;
         hex_dp_o  <= ~dp_q[idx_q];
      end
   end

endmodule
